user_id_shift_ctrl: RTL and testbench

- Controller that shares the constant user project ID (the 32-bit mask_rev value) between two requesters, e.g. the housekeeping SPI and a Wishbone-side reader.
- Arbitrates round-robin between the requesters and snapshots the ID.
- Shifts the ID out MSB-first on a single serial line at a programmable bit rate, then signals completion to the granted requester.
- Sits between the user ID programming block and the housekeeping logic.

---
 rtl/user_id_shift_ctrl.sv | 150 +++++++++++++++
 tb/tb_user_id_shift_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/user_id_shift_ctrl.sv
// rtl/user_id_shift_ctrl.sv - round-robin shared reader that serialises the user project ID
//
// Purpose: two requesters share the constant user project ID. The controller
// grants one of them round-robin, snapshots the ID and divider, shifts the ID
// out MSB-first on sdo_o at a programmable bit rate, then pulses done_o.
//
// Ports:
//   wb_clk_i      system clock, rising edge
//   wb_rst_i      synchronous active-high reset
//   mask_rev_i    user project ID from the ID programming block
//   req_i         level requests, bit n = requester n
//   div_i         bit period minus one, in clocks
//   gnt_o         one-hot grant, held for the whole transaction
//   busy_o        transaction in progress
//   sdo_o         serial ID, MSB first
//   sdo_strobe_o  last cycle of each bit period
//   done_o        one-cycle completion pulse to the granted requester
//   id_latched_o  ID snapshot taken at grant
module user_id_shift_ctrl #(
   parameter int ID_WIDTH  = 32,
   parameter int DIV_WIDTH = 8
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [ID_WIDTH-1:0]  mask_rev_i,
   input  logic [1:0]           req_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic [1:0]           gnt_o,
   output logic                 busy_o,
   output logic                 sdo_o,
   output logic                 sdo_strobe_o,
   output logic [1:0]           done_o,
   output logic [ID_WIDTH-1:0]  id_latched_o
);

   localparam int BCW = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(ID_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           gnt_q, gnt_d;
   logic [ID_WIDTH-1:0]  shreg_q, shreg_d;
   logic [ID_WIDTH-1:0]  id_q, id_d;
   logic [DIV_WIDTH-1:0] period_q, period_d;
   logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                 last_q, last_d;   // index of the last requester served
   logic                 bit_end;
   logic                 granted_req;
   logic                 win;

   assign bit_end     = (state_q == SHIFT) && (div_cnt_q == period_q);
   assign granted_req = |(req_i & gnt_q);

   // On a tie the requester that was not served last wins.
   always_comb begin
      win = 1'b0;
      case (req_i)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         default: win = ~last_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      shreg_d   = shreg_q;
      id_d      = id_q;
      period_d  = period_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      last_d    = last_q;
      case (state_q)
         IDLE: begin
            if (req_i != 2'b00) begin
               gnt_d     = win ? 2'b10 : 2'b01;
               shreg_d   = mask_rev_i;
               id_d      = mask_rev_i;
               period_d  = div_i;
               div_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // Losing the request abandons the transfer without a done pulse.
            if (!granted_req) begin
               state_d = IDLE;
               gnt_d   = 2'b00;
               last_d  = gnt_q[1];
            end else if (bit_end) begin
               div_cnt_d = '0;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = DONE;
               end else begin
                  shreg_d   = shreg_q << 1;
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            last_d  = gnt_q[1];
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         gnt_q     <= 2'b00;
         shreg_q   <= '0;
         id_q      <= '0;
         period_q  <= '0;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         shreg_q   <= shreg_d;
         id_q      <= id_d;
         period_q  <= period_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         last_q    <= last_d;
      end
   end

   assign gnt_o        = gnt_q;
   assign busy_o       = (state_q != IDLE);
   assign sdo_o        = (state_q == SHIFT) && shreg_q[ID_WIDTH-1];
   assign sdo_strobe_o = bit_end;
   assign done_o       = (state_q == DONE) ? gnt_q : 2'b00;
   assign id_latched_o = id_q;

endmodule

// File: tb/tb_user_id_shift_ctrl.sv
// tb/tb_user_id_shift_ctrl.sv - scoreboard bench for user_id_shift_ctrl
module tb_user_id_shift_ctrl;
   localparam int W = 32;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i;
   logic [W-1:0]  mask_rev_i;
   logic [1:0]    req_i;
   logic [7:0]    div_i;
   logic [1:0]    gnt_o;
   logic          busy_o;
   logic          sdo_o;
   logic          sdo_strobe_o;
   logic [1:0]    done_o;
   logic [W-1:0]  id_latched_o;

   user_id_shift_ctrl #(.ID_WIDTH(W), .DIV_WIDTH(8)) dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_i     (wb_rst_i),
      .mask_rev_i   (mask_rev_i),
      .req_i        (req_i),
      .div_i        (div_i),
      .gnt_o        (gnt_o),
      .busy_o       (busy_o),
      .sdo_o        (sdo_o),
      .sdo_strobe_o (sdo_strobe_o),
      .done_o       (done_o),
      .id_latched_o (id_latched_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int compared = 0;
   int failed   = 0;

   typedef struct {
      logic [1:0]   gnt;
      logic [W-1:0] id;
      int           d;
      int           len;
   } exp_t;

   exp_t         exp_q[$];
   int           ptr = 1;
   bit           mon_en = 1'b0;
   bit           in_txn = 1'b0;
   logic         sdo_tr[$];
   logic         stb_tr[$];
   logic [1:0]   done_tr[$];
   logic [1:0]   gnt_tr[$];
   logic [W-1:0] id_tr[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [1:0] r);
      if (r == 2'b01) return 0;
      if (r == 2'b10) return 1;
      return (ptr == 0) ? 1 : 0;
   endfunction

   // abort_len = 0 means the transfer runs to completion.
   task automatic push_txn(input logic [1:0] r, input logic [W-1:0] id, input int d, input int abort_len);
      exp_t e;
      int   w;
      w     = pick(r);
      e.gnt = (w == 1) ? 2'b10 : 2'b01;
      e.id  = id;
      e.d   = d;
      e.len = (abort_len == 0) ? W * (d + 1) + 1 : abort_len;
      exp_q.push_back(e);
      ptr = w;
   endtask

   task automatic wait_busy(input logic lvl, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge wb_clk_i);
         n++;
      end while (busy_o !== lvl && n < 1000);
      check(tag, busy_o, lvl);
   endtask

   // mode: 0 keep inputs, 1 scramble mask/div, 2 mask all-ones during the shift
   task automatic run_txn(input logic [1:0] r, input logic [W-1:0] id, input int d,
                          input int abort_c, input int mode);
      mask_rev_i = id;
      div_i      = 8'(d);
      req_i      = r;
      push_txn(r, id, d, (abort_c > 0) ? abort_c + 1 : 0);
      wait_busy(1'b1, "grant_wait");
      if (mode == 1) begin
         mask_rev_i = $urandom;
         div_i      = 8'($urandom);
      end else if (mode == 2) begin
         mask_rev_i = 32'hFFFF_FFFF;
      end
      if (abort_c > 0) begin
         repeat (abort_c) @(posedge wb_clk_i);
         #1 req_i = 2'b00;
      end
      wait_busy(1'b0, "release_wait");
      req_i = 2'b00;
   endtask

   task automatic end_txn();
      exp_t e;
      int   errs;
      int   n;
      check("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
         e    = exp_q.pop_front();
         n    = sdo_tr.size();
         errs = 0;
         check("gnt", gnt_tr[0], e.gnt);
         check("id_latched", id_tr[0], e.id);
         check("busy_len", n, e.len);
         for (int i = 0; i < n && i < e.len; i++) begin
            logic       es;
            logic       et;
            logic [1:0] ed;
            if (i < W * (e.d + 1)) begin
               es = e.id[W - 1 - i / (e.d + 1)];
               et = ((i % (e.d + 1)) == e.d);
               ed = 2'b00;
            end else begin
               es = 1'b0;
               et = 1'b0;
               ed = e.gnt;
            end
            if (sdo_tr[i] !== es || stb_tr[i] !== et || done_tr[i] !== ed ||
                gnt_tr[i] !== e.gnt || id_tr[i] !== e.id)
               errs++;
         end
         check("trace_errs", errs, 0);
      end
      sdo_tr.delete();
      stb_tr.delete();
      done_tr.delete();
      gnt_tr.delete();
      id_tr.delete();
   endtask

   // Monitor: collects each busy window and scores it against the queue.
   initial begin
      forever begin
         @(negedge wb_clk_i);
         if (mon_en) begin
            if (busy_o === 1'b1) begin
               in_txn = 1'b1;
               sdo_tr.push_back(sdo_o);
               stb_tr.push_back(sdo_strobe_o);
               done_tr.push_back(done_o);
               gnt_tr.push_back(gnt_o);
               id_tr.push_back(id_latched_o);
            end else begin
               if (in_txn) begin
                  in_txn = 1'b0;
                  end_txn();
               end
               check("idle_outputs", {gnt_o, sdo_o, sdo_strobe_o, done_o}, 6'd0);
            end
         end
      end
   end

   initial begin
      int d;
      int c;
      logic [1:0] r;
      wb_rst_i   = 1'b1;
      req_i      = 2'b00;
      mask_rev_i = '0;
      div_i      = '0;
      repeat (2) @(negedge wb_clk_i);
      check("rst_gnt", gnt_o, 2'b00);
      check("rst_busy", busy_o, 1'b0);
      check("rst_sdo", sdo_o, 1'b0);
      check("rst_strobe", sdo_strobe_o, 1'b0);
      check("rst_done", done_o, 2'b00);
      check("rst_id", id_latched_o, 32'h0);
      @(posedge wb_clk_i);
      #1 wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      mon_en = 1'b1;

      // Tie from reset with both requests held: 0, 1, 0.
      mask_rev_i = 32'hC0DE_0001;
      div_i      = 8'd0;
      req_i      = 2'b11;
      for (int k = 0; k < 3; k++) begin
         push_txn(2'b11, 32'hC0DE_0001, 0, 0);
         wait_busy(1'b1, "tie_grant_wait");
         wait_busy(1'b0, "tie_release_wait");
      end
      req_i = 2'b00;

      // Single request, one bit per cycle.
      run_txn(2'b01, 32'hA5C3_0F01, 0, 0, 0);
      check("id_hold_a5", id_latched_o, 32'hA5C3_0F01);

      // Divided bit period.
      run_txn(2'b01, 32'h8000_0001, 3, 0, 0);

      // Abort requester 1 after 5 bits, then a tie must go to requester 0.
      run_txn(2'b10, 32'h5A5A_F00F, 1, 9, 0);
      run_txn(2'b11, 32'h0F0F_3C3C, 0, 0, 0);

      // Reset in the middle of bit 10, request held through it.
      mask_rev_i = 32'hDEAD_BEEF;
      div_i      = 8'd1;
      req_i      = 2'b10;
      push_txn(2'b10, 32'hDEAD_BEEF, 1, 21);
      wait_busy(1'b1, "rst_grant_wait");
      repeat (20) @(posedge wb_clk_i);
      #1 wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      #1 wb_rst_i = 1'b0;
      ptr = 1;
      push_txn(2'b10, 32'hDEAD_BEEF, 1, 0);
      @(negedge wb_clk_i);
      check("midrst_id", id_latched_o, 32'h0);
      check("midrst_busy", busy_o, 1'b0);
      check("midrst_gnt", gnt_o, 2'b00);
      wait_busy(1'b1, "rst_regrant_wait");
      wait_busy(1'b0, "rst_release_wait");
      req_i = 2'b00;

      // Snapshot must ignore mask_rev_i changes while shifting.
      run_txn(2'b01, 32'h1234_5678, 1, 0, 2);
      check("id_hold_snap", id_latched_o, 32'h1234_5678);

      // Randomised transactions.
      for (int k = 0; k < 16; k++) begin
         case ($urandom_range(0, 2))
            0:       r = 2'b01;
            1:       r = 2'b10;
            default: r = 2'b11;
         endcase
         d = $urandom_range(0, 4);
         c = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W * (d + 1) - 1) : 0;
         run_txn(r, $urandom, d, c, 1);
         if ($urandom_range(0, 1) == 1) @(negedge wb_clk_i);
      end

      repeat (4) @(negedge wb_clk_i);
      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
